// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states
// and the alignment rule used to reject requests.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_LOAD_WAIT = 2'b01,
    S_RMW_READ  = 2'b10,
    S_RMW_WRITE = 2'b11
  } state_e;

  // Halfwords must sit on an even byte, words on a 4-byte boundary.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] offset);
    return ((size == SZ_HALF) && offset[0]) ||
           ((size == SZ_WORD) && (offset != 2'b00)) ||
           (size == SZ_ILLEGAL);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts and extends load data, and merges
// sub-word store data into an existing memory word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] ld_word_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_signed_i,
  output logic [31:0] ld_data_o,
  input  logic [31:0] st_old_i,
  input  logic [31:0] st_wdata_i,
  input  logic [1:0]  st_offset_i,
  input  logic [1:0]  st_size_i,
  output logic [31:0] st_word_o
);

  logic [31:0] ld_lane;

  // Shift the addressed lane down to bit 0 before extending.
  assign ld_lane = ld_word_i >> {ld_offset_i, 3'b000};

  always_comb begin
    ld_data_o = ld_word_i;
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{ld_signed_i & ld_lane[7]}}, ld_lane[7:0]};
      SZ_HALF: ld_data_o = {{16{ld_signed_i & ld_lane[15]}}, ld_lane[15:0]};
      default: ld_data_o = ld_word_i;
    endcase
  end

  always_comb begin
    st_word_o = st_wdata_i;
    case (st_size_i)
      SZ_BYTE: begin
        st_word_o = st_old_i;
        st_word_o[{st_offset_i, 3'b000} +: 8] = st_wdata_i[7:0];
      end
      SZ_HALF: begin
        st_word_o = st_old_i;
        st_word_o[{st_offset_i[1], 4'b0000} +: 16] = st_wdata_i[15:0];
      end
      default: st_word_o = st_wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end for a synchronous-read, word-addressed
// DataMemory: word stores in one cycle, loads in two, sub-word stores via RMW.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken only in IDLE while req_valid is high; while
  // stall is high the MEM stage must hold its request, and all request inputs
  // are ignored outside IDLE. rdata_valid and misalign are single-cycle pulses.

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        misalign_q, misalign_d;

  logic        req_bad;
  logic        req_accept;
  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic [31:0] unused_addr_width;

  // The memory depth is documented here only; range handling is DataMemory's.
  assign unused_addr_width = 32'(ADDR_WIDTH);

  assign req_bad    = is_misaligned(req_size, req_addr[1:0]);
  assign req_accept = (state_q == S_IDLE) && req_valid && !req_bad;

  mem_lane_align u_lane_align (
    .ld_word_i   (mem_dout),
    .ld_offset_i (addr_q[1:0]),
    .ld_size_i   (size_q),
    .ld_signed_i (signed_q),
    .ld_data_o   (ld_data),
    .st_old_i    (merge_q),
    .st_wdata_i  (wdata_q),
    .st_offset_i (addr_q[1:0]),
    .st_size_i   (size_q),
    .st_word_o   (st_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_accept) begin
          if (!req_we)                  state_d = S_LOAD_WAIT;
          else if (req_size != SZ_WORD) state_d = S_RMW_READ;
        end
      end
      S_LOAD_WAIT: state_d = S_IDLE;
      S_RMW_READ:  state_d = S_RMW_WRITE;
      S_RMW_WRITE: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    mem_we   = 1'b0;
    mem_din  = 32'd0;
    mem_addr = {2'b00, addr_q[31:2]};
    case (state_q)
      S_IDLE: begin
        mem_addr = {2'b00, req_addr[31:2]};
        if (req_accept) begin
          if (req_we && (req_size == SZ_WORD)) begin
            mem_we  = 1'b1;
            mem_din = req_wdata;
          end else begin
            stall = 1'b1;
          end
        end
      end
      S_RMW_READ: stall = 1'b1;
      S_RMW_WRITE: begin
        mem_we  = 1'b1;
        mem_din = st_word;
      end
      default: ;
    endcase
  end

  // Request latch, RMW merge word and registered load result.
  always_comb begin
    addr_d        = addr_q;
    size_d        = size_q;
    signed_d      = signed_q;
    wdata_d       = wdata_q;
    merge_d       = merge_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    misalign_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_bad) misalign_d = 1'b1;
        if (req_accept) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata;
        end
      end
      S_LOAD_WAIT: begin
        rdata_d       = ld_data;
        rdata_valid_d = 1'b1;
      end
      S_RMW_READ: merge_d = mem_dout;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= 32'd0;
      size_q        <= 2'd0;
      signed_q      <= 1'b0;
      wdata_q       <= 32'd0;
      merge_q       <= 32'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      wdata_q       <= wdata_d;
      merge_q       <= merge_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign misalign    = misalign_q;
  assign dbg_state   = state_q;

endmodule
